// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types: elastic stage FSM states and inter-stage payload structs
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } pipe_state_e;

    localparam int XLEN       = 32;
    localparam int PC_W       = 32;
    localparam int REG_NUM_W  = 5;
    localparam int ALU_CTRL_W = 4;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       mem_sign;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [PC_W-1:0] pc;
        logic            halted;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0]       val1;
        logic [XLEN-1:0]       val2;
        logic [XLEN-1:0]       saved_val;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        mem_ctrl_t             mem_ctrl;
        wb_ctrl_t              wb_ctrl;
        logic                  jump;
        logic [PC_W-1:0]       pc;
        logic [REG_NUM_W-1:0]  dest_reg_num;
        logic                  halted;
    } id_exe_t;

    typedef struct packed {
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      saved_val;
        mem_ctrl_t            mem_ctrl;
        wb_ctrl_t             wb_ctrl;
        logic [REG_NUM_W-1:0] dest_reg_num;
        logic                 halted;
    } exe_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]      wb_val;
        wb_ctrl_t             wb_ctrl;
        logic [REG_NUM_W-1:0] dest_reg_num;
        logic                 halted;
    } mem_wb_t;

    localparam int IF_ID_W   = $bits(if_id_t);
    localparam int ID_EXE_W  = $bits(id_exe_t);
    localparam int EXE_MEM_W = $bits(exe_mem_t);
    localparam int MEM_WB_W  = $bits(mem_wb_t);

    function automatic logic [1:0] state_occ(input pipe_state_e s);
        case (s)
            FULL:      return 2'd1;
            SKID_FULL: return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_hold_reg.sv
// rtl/pipe_hold_reg.sv - payload holding register with load and synchronous clear to RESET_VAL
module pipe_hold_reg #(
    parameter int               WIDTH     = 128,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q <= RESET_VAL;
        end else if (clear) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic inter-stage pipeline register with stall, flush and optional skid entry
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 128,
    parameter int               SKID      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             freeze,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    pipe_state_e      state;
    logic             push;
    logic             pop;
    logic             main_load;
    logic             skid_load;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign out_valid = (state != EMPTY) & ~freeze;
    assign out_data  = main_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // rst_b gating keeps in_ready low while reset is held without adding a flop,
    // so the first edge after release can already accept a beat.
    generate
        if (SKID != 0) begin : g_rdy_skid
            assign in_ready = rst_b & ~freeze & (state != SKID_FULL);
        end else begin : g_rdy_noskid
            assign in_ready = rst_b & ~freeze & ((state == EMPTY) | out_ready);
        end
    endgenerate

    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_data;
        unique case (state)
            EMPTY: begin
                main_load = push;
            end
            FULL: begin
                main_load = push & pop;
                skid_load = (SKID != 0) & push & ~pop;
            end
            SKID_FULL: begin
                main_load = pop;
                main_d    = skid_q;
            end
            default: begin
                main_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= EMPTY;
            occ   <= state_occ(EMPTY);
        end else if (flush) begin
            state <= EMPTY;
            occ   <= state_occ(EMPTY);
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        state <= FULL;
                        occ   <= state_occ(FULL);
                    end
                end
                FULL: begin
                    if (push && !pop && (SKID != 0)) begin
                        state <= SKID_FULL;
                        occ   <= state_occ(SKID_FULL);
                    end else if (pop && !push) begin
                        state <= EMPTY;
                        occ   <= state_occ(EMPTY);
                    end
                end
                SKID_FULL: begin
                    if (pop) begin
                        state <= FULL;
                        occ   <= state_occ(FULL);
                    end
                end
                default: begin
                    state <= EMPTY;
                    occ   <= state_occ(EMPTY);
                end
            endcase
        end
    end

    pipe_hold_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .rst_b (rst_b),
        .load  (main_load),
        .clear (flush),
        .d     (main_d),
        .q     (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_hold_reg #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_skid (
                .clk   (clk),
                .rst_b (rst_b),
                .load  (skid_load),
                .clear (flush),
                .d     (in_data),
                .q     (skid_q)
            );
        end else begin : g_noskid
            assign skid_q = RESET_VAL;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for pipe_stage_elastic, skid and no-skid variants
module tb_pipe_stage_elastic;

    localparam logic [15:0] RV_A = 16'hDEAD;
    localparam logic [15:0] RV_B = 16'hBEEF;

    logic        clk;
    logic        rst_b;

    logic        a_freeze, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;

    logic        b_freeze, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] ea, eb;

    int total = 0;
    int bad   = 0;

    pipe_stage_elastic #(.WIDTH(16), .SKID(1), .RESET_VAL(RV_A)) dut_a (
        .clk(clk), .rst_b(rst_b), .freeze(a_freeze), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occ(a_occ)
    );

    pipe_stage_elastic #(.WIDTH(16), .SKID(0), .RESET_VAL(RV_B)) dut_b (
        .clk(clk), .rst_b(rst_b), .freeze(b_freeze), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occ(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every downstream handshake must match the head of its scoreboard.
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_beat: got %0h want none", a_out_data);
            end else begin
                ea = qa.pop_front();
                chk("a_out_data", int'(a_out_data), int'(ea));
            end
        end
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_beat: got %0h want none", b_out_data);
            end else begin
                eb = qb.pop_front();
                chk("b_out_data", int'(b_out_data), int'(eb));
            end
        end
    end

    initial begin
        rst_b = 1'b0;
        a_freeze = 0; a_flush = 0; a_in_valid = 1; a_in_data = 16'h0077; a_out_ready = 1;
        b_freeze = 0; b_flush = 0; b_in_valid = 0; b_in_data = 16'h0000; b_out_ready = 1;

        // 1: reset with in_valid held high
        step();
        step();
        #1;
        chk("rst_out_valid", int'(a_out_valid), 0);
        chk("rst_in_ready",  int'(a_in_ready),  0);
        chk("rst_occ",       int'(a_occ),       0);
        chk("rst_out_data",  int'(a_out_data),  int'(RV_A));
        chk("rst_b_out_data", int'(b_out_data), int'(RV_B));
        step();
        rst_b = 1'b1;
        a_in_data = 16'h00A5;
        qa.push_back(16'h00A5);
        #1;
        chk("rel_in_ready", int'(a_in_ready), 1);
        step();
        a_in_valid = 0;
        #1;
        chk("t1_occ", int'(a_occ), 1);
        chk("t1_out_valid", int'(a_out_valid), 1);
        step();
        #1;
        chk("t1_empty", int'(a_occ), 0);

        // 2: streaming at full rate
        step();
        a_out_ready = 1;
        for (int i = 1; i <= 3; i++) begin
            a_in_valid = 1;
            a_in_data  = 16'(i);
            qa.push_back(16'(i));
            step();
            #1;
            chk("t2_occ", int'(a_occ), 1);
            chk("t2_no_bubble", int'(a_out_valid), 1);
        end
        a_in_valid = 0;
        step();
        #1;
        chk("t2_drained", int'(a_occ), 0);

        // 3: backpressure fills the skid entry
        step();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 16'h0010; qa.push_back(16'h0010);
        step();
        a_in_data = 16'h0011; qa.push_back(16'h0011);
        #1;
        chk("t3_rdy_full", int'(a_in_ready), 1);
        step();
        a_in_data = 16'h0012;
        #1;
        chk("t3_occ2", int'(a_occ), 2);
        chk("t3_rdy_skid", int'(a_in_ready), 0);
        step();
        #1;
        chk("t3_held_occ", int'(a_occ), 2);
        step();
        a_out_ready = 1;
        qa.push_back(16'h0012);
        #1;
        chk("t3_rdy_pop_cycle", int'(a_in_ready), 0);
        step();
        #1;
        chk("t3_rdy_after_pop", int'(a_in_ready), 1);
        step();
        a_in_valid = 0;
        #1;
        chk("t3_occ_last", int'(a_occ), 1);
        step();
        #1;
        chk("t3_drained", int'(a_occ), 0);

        // 4: freeze holds everything
        step();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 16'h0020; qa.push_back(16'h0020);
        step();
        a_freeze = 1; a_in_data = 16'h0021; a_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_out_valid", int'(a_out_valid), 0);
            chk("t4_in_ready",  int'(a_in_ready),  0);
            chk("t4_occ",       int'(a_occ),       1);
            step();
        end
        a_freeze = 0; a_in_valid = 0;
        #1;
        chk("t4_release_valid", int'(a_out_valid), 1);
        chk("t4_release_data",  int'(a_out_data),  'h20);
        step();
        #1;
        chk("t4_drained", int'(a_occ), 0);

        // 5: flush dominates freeze and push
        step();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 16'h0030; qa.push_back(16'h0030);
        step();
        a_in_data = 16'h0031; qa.push_back(16'h0031);
        step();
        #1;
        chk("t5_occ2", int'(a_occ), 2);
        a_flush = 1; a_freeze = 1; a_in_data = 16'h0032; a_out_ready = 1;
        step();
        a_flush = 0; a_freeze = 0; a_in_valid = 0;
        qa.delete();
        #1;
        chk("t5_occ", int'(a_occ), 0);
        chk("t5_out_valid", int'(a_out_valid), 0);
        chk("t5_out_data", int'(a_out_data), int'(RV_A));
        step();
        #1;
        chk("t5_still_empty", int'(a_out_valid), 0);
        // pop in the flush cycle still reaches downstream; the concurrent push is lost
        step();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 16'h0040; qa.push_back(16'h0040);
        step();
        a_in_data = 16'h0041; a_flush = 1; a_out_ready = 1;
        step();
        a_flush = 0; a_in_valid = 0;
        #1;
        chk("t5b_occ", int'(a_occ), 0);
        chk("t5b_out_valid", int'(a_out_valid), 0);

        // 6: no-skid variant, combinational in_ready
        step();
        b_out_ready = 0;
        b_in_valid = 1; b_in_data = 16'h0050; qb.push_back(16'h0050);
        #1;
        chk("t6_rdy_empty", int'(b_in_ready), 1);
        step();
        b_in_data = 16'h0051;
        #1;
        chk("t6_rdy_blocked", int'(b_in_ready), 0);
        b_out_ready = 1;
        qb.push_back(16'h0051);
        #1;
        chk("t6_rdy_follow", int'(b_in_ready), 1);
        step();
        #1;
        chk("t6_occ", int'(b_occ), 1);
        b_in_data = 16'h0052; qb.push_back(16'h0052);
        step();
        b_in_valid = 0;
        #1;
        chk("t6_occ_stay", int'(b_occ), 1);
        chk("t6_data", int'(b_out_data), 'h52);
        step();
        #1;
        chk("t6_drained", int'(b_occ), 0);

        // 7: async reset mid-transfer
        step();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 16'h0060; qa.push_back(16'h0060);
        step();
        a_in_valid = 0;
        #1;
        chk("t7_occ_before", int'(a_occ), 1);
        rst_b = 1'b0;
        #1;
        chk("t7_out_valid", int'(a_out_valid), 0);
        chk("t7_occ", int'(a_occ), 0);
        chk("t7_out_data", int'(a_out_data), int'(RV_A));
        chk("t7_in_ready", int'(a_in_ready), 0);
        qa.delete();
        step();
        rst_b = 1'b1;
        a_in_valid = 1; a_in_data = 16'h0061; a_out_ready = 1;
        qa.push_back(16'h0061);
        #1;
        chk("t7_rdy_release", int'(a_in_ready), 1);
        step();
        a_in_valid = 0;
        #1;
        chk("t7_data", int'(a_out_data), 'h61);
        step();
        step();
        step();

        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
